// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that resolves DIGIT bits per clock, LSB digit first.
// Results (sum, c_out, overflow) use valid/ready handshakes on both sides.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;
    logic             msb_carry;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_dig = a_reg[i*DIGIT +: DIGIT];
                b_dig = b_reg[i*DIGIT +: DIGIT];
            end
        end
    end

    assign dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_reg};
    // Carry into the top bit of the digit recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_carry = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign work_next[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ?
                dig_sum[DIGIT-1:0] : work_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= c_in ^ sub;
                        cnt_reg   <= '0;
                        work_reg  <= '0;
                        state_reg <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= dig_sum[DIGIT];
                    if (cnt_reg == LAST) begin
                        sum       <= work_next;
                        c_out     <= dig_sum[DIGIT];
                        overflow  <= msb_carry ^ dig_sum[DIGIT];
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // No bypass: in_ready only returns once DONE has been left.
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8/1 instance with randomized traffic and backpressure,
// plus 16/4 and 16/16 instances for latency and wide-carry checks.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       c_in = 1'b0, sub = 1'b0;
    logic       in_ready, out_valid, c_out, overflow, busy;
    logic [7:0] sum;

    logic        in_valid16 = 1'b0;
    logic        out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        c_in16 = 1'b0, sub16 = 1'b0;
    logic        ir4, ov4, co4, of4, bz4, ir16, ov16, co16, of16, bz16;
    logic [15:0] s4, s16;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .overflow(overflow), .busy(busy));

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir4), .a(a16), .b(b16),
        .c_in(c_in16), .sub(sub16), .out_valid(ov4), .out_ready(out_ready16), .sum(s4),
        .c_out(co4), .overflow(of4), .busy(bz4));

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir16), .a(a16), .b(b16),
        .c_in(c_in16), .sub(sub16), .out_valid(ov16), .out_ready(out_ready16), .sum(s16),
        .c_out(co16), .overflow(of16), .busy(bz16));

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     n_issued = 0;
    int     n_results = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with a signed-range test for overflow.
    function automatic void model(input int w, input longint av, input longint bv,
                                  input bit cin, input bit sb,
                                  output longint s, output bit co, output bit ov);
        longint m, bb, cc, full, half, sa, sbb, tot;
        m    = (longint'(1) << w) - 1;
        bb   = sb ? (~bv & m) : bv;
        cc   = longint'(cin ^ sb);
        full = av + bb + cc;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - (m + 1) : av;
        sbb  = (bb >= half) ? bb - (m + 1) : bb;
        tot  = sa + sbb + cc;
        s    = full & m;
        co   = ((full >> w) & 1) != 0;
        ov   = (tot >= half) || (tot < -half);
    endfunction

    typedef struct {
        logic [7:0] s;
        bit         co;
        bit         ov;
        longint     acc;
    } exp_t;
    exp_t exp_q[$];

    longint m_s;
    bit     m_co, m_ov;
    exp_t   m_e;

    // Input side: an accepted operation pushes its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            model(8, longint'(a), longint'(b), c_in, sub, m_s, m_co, m_ov);
            m_e.s   = m_s[7:0];
            m_e.co  = m_co;
            m_e.ov  = m_ov;
            m_e.acc = cyc + 1;
            exp_q.push_back(m_e);
            n_issued++;
            $display("issue   a=%02h b=%02h c_in=%0d sub=%0d exp_sum=%02h", a, b, c_in, sub, m_e.s);
        end
    end

    bit         prev_ov = 1'b0;
    bit         exp_idle = 1'b0;
    logic [7:0] held_sum, last_sum;
    logic       held_co, held_of, last_co, last_of;
    exp_t       o_e;

    // Output side: pop and compare on each new result; check hold and handshake rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (!prev_ov) begin
                    n_results++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result actual sum=%02h required=no result", sum);
                    end else begin
                        o_e = exp_q.pop_front();
                        chk("sum", longint'(sum), longint'(o_e.s));
                        chk("c_out", longint'(c_out), longint'(o_e.co));
                        chk("overflow", longint'(overflow), longint'(o_e.ov));
                        chk("latency", cyc - o_e.acc, 8);
                        $display("result  sum=%02h c_out=%0d overflow=%0d", sum, c_out, overflow);
                    end
                    held_sum = sum; held_co = c_out; held_of = overflow;
                    last_sum = sum; last_co = c_out; last_of = overflow;
                end else begin
                    chk("hold_sum", longint'(sum), longint'(held_sum));
                    chk("hold_c_out", longint'(c_out), longint'(held_co));
                    chk("hold_overflow", longint'(overflow), longint'(held_of));
                end
                chk("in_ready_in_done", longint'(in_ready), 0);
                exp_idle = out_ready;
            end else begin
                if (exp_idle) chk("in_ready_after_accept", longint'(in_ready), 1);
                exp_idle = 1'b0;
                chk("busy_vs_ready", longint'(busy), longint'(!in_ready));
            end
            prev_ov = out_valid;
        end else begin
            prev_ov  = 1'b0;
            exp_idle = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit ci, input bit sb,
                         input int hold, input bit noise);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin tick(); t++; end
        checks++;
        if (t >= 200) begin failures++; $display("FAIL timeout_in_ready actual=0 required=1"); end
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        if (noise) begin
            a = 8'hAA;
            b = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        t = 0;
        while (!out_valid && t < 200) begin tick(); t++; end
        checks++;
        if (t >= 200) begin failures++; $display("FAIL timeout_out_valid actual=0 required=1"); end
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input bit ci, input bit sb);
        int t, lat4, lat16;
        logic [15:0] r4, r16;
        bit rc4, rc16, ro4, ro16, eco, eov;
        longint es;
        t = 0;
        while (!(ir4 && ir16) && t < 100) begin tick(); t++; end
        a16 = av; b16 = bv; c_in16 = ci; sub16 = sb; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        lat4 = -1; lat16 = -1;
        r4 = '0; r16 = '0; rc4 = 0; rc16 = 0; ro4 = 0; ro16 = 0;
        for (int c = 0; c <= 10; c++) begin
            if (ov4 && lat4 < 0) begin lat4 = c; r4 = s4; rc4 = co4; ro4 = of4; end
            if (ov16 && lat16 < 0) begin lat16 = c; r16 = s16; rc16 = co16; ro16 = of16; end
            tick();
        end
        model(16, longint'(av), longint'(bv), ci, sb, es, eco, eov);
        chk("latency_d4", lat4, 4);
        chk("latency_d16", lat16, 1);
        chk("sum_d4", longint'(r4), es);
        chk("sum_d16", longint'(r16), es);
        chk("c_out_d4", longint'(rc4), longint'(eco));
        chk("c_out_d16", longint'(rc16), longint'(eco));
        chk("overflow_d4", longint'(ro4), longint'(eov));
        chk("overflow_d16", longint'(ro16), longint'(eov));
        $display("wide    a=%04h b=%04h sub=%0d sum4=%04h sum16=%04h lat=%0d/%0d",
                 av, bv, sb, r4, r16, lat4, lat16);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] av, bv;
        bit ci, sb;
        logic [7:0] es;
        bit eco, eov;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_sum", longint'(sum), 0);
        chk("reset_c_out", longint'(c_out), 0);
        chk("reset_overflow", longint'(overflow), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].av, vecs[i].bv, vecs[i].ci, vecs[i].sb, 0, 1'b0);
            chk("dir_sum", longint'(last_sum), longint'(vecs[i].es));
            chk("dir_c_out", longint'(last_co), longint'(vecs[i].eco));
            chk("dir_overflow", longint'(last_of), longint'(vecs[i].eov));
        end

        // Backpressure with a competing operand held on the input throughout.
        do_op(8'h33, 8'h44, 1'b0, 1'b0, 5, 1'b1);
        chk("bp_sum", longint'(last_sum), 8'h77);

        // Abort three cycles into RUN.
        a = 8'h11; b = 8'h22; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_sum", longint'(sum), 0);
        chk("abort_c_out", longint'(c_out), 0);
        chk("abort_overflow", longint'(overflow), 0);
        exp_q.delete();
        n_issued--;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        do_op(8'h02, 8'h03, 1'b0, 1'b0, 0, 1'b0);
        chk("post_reset_sum", longint'(last_sum), 8'h05);

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (5) tick();
        chk("queue_empty", longint'(exp_q.size()), 0);
        chk("result_count", longint'(n_results), longint'(n_issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
